// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among NUM_CORES cores.
// Returns per-core read data and status, and aggregates the cores' end-of-process flags.
module dram_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RD_LAT    = 2,
    localparam int unsigned ID_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_wren,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    input  logic [NUM_CORES-1:0]          core_end,
    input  logic [DATA_W-1:0]             dram_q,
    output logic [ADDR_W-1:0]             dram_addr,
    output logic [DATA_W-1:0]             dram_wdata,
    output logic                          dram_wren,
    output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
    output logic [2*NUM_CORES-1:0]        core_status,
    output logic [ID_W-1:0]               grant_id,
    output logic                          all_done
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned SUM_W = ID_W + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      win_id;
    logic                 win_found;
    logic                 last_wait;
    logic [CNT_W-1:0]     wait_cnt;
    logic [SUM_W-1:0]     cand;
    logic [NUM_CORES-1:0] end_seen;
    logic [NUM_CORES-1:0] end_seen_next;
    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
    logic [DATA_W-1:0]    rdata_arr [NUM_CORES];

    // Unpack flat core buses into per-core arrays and repack read data.
    always_comb begin : unpack
        for (int i = 0; i < NUM_CORES; i++) begin
            addr_arr[i]                    = core_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i]                   = core_wdata[i*DATA_W +: DATA_W];
            core_rdata[i*DATA_W +: DATA_W] = rdata_arr[i];
        end
    end

    // Scan downward so the requester closest at/after rr_ptr is the final assignment.
    always_comb begin : pick
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_CORES)) begin
                cand = cand - SUM_W'(NUM_CORES);
            end
            if (core_req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    assign last_wait     = (wait_cnt == CNT_W'(RD_LAT - 1));
    assign end_seen_next = end_seen | core_end;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : fsm_next
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = ACCESS;
            ACCESS:  state_next = dram_wren ? DONE : WAIT;
            WAIT:    if (last_wait) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // DRAM command, read capture and round-robin pointer update.
    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_wren  <= 1'b0;
            wait_cnt   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                rdata_arr[i] <= '0;
            end
        end else begin
            dram_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id   <= win_id;
                        dram_addr  <= addr_arr[win_id];
                        dram_wdata <= wdata_arr[win_id];
                        dram_wren  <= core_wren[win_id];
                    end
                end
                ACCESS: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (last_wait) begin
                        rdata_arr[grant_id] <= dram_q;
                    end
                end
                DONE: rr_ptr <= (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
                default: ;
            endcase
        end
    end

    // all_done uses the next flag value so it rises the cycle after the last end is seen.
    always_ff @(posedge clk) begin : end_track
        if (rst) begin
            end_seen <= '0;
            all_done <= 1'b0;
        end else begin
            end_seen <= end_seen_next;
            all_done <= &end_seen_next;
        end
    end

    always_comb begin : status
        core_status = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state == DONE && grant_id == ID_W'(i)) begin
                core_status[2*i +: 2] = 2'b10;
            end else if (core_req[i]) begin
                core_status[2*i +: 2] = 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: DRAM model, expected-transaction queue and
// directed timing checks for read, write, round robin, request drop, reset and end aggregation.
module tb_dram_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;

    typedef struct {
        int          core;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_wren;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_end;
    logic [DW-1:0]     dram_q;
    logic [AW-1:0]     dram_addr;
    logic [DW-1:0]     dram_wdata;
    logic              dram_wren;
    logic [NC*DW-1:0]  core_rdata;
    logic [2*NC-1:0]   core_status;
    logic [1:0]        grant_id;
    logic              all_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;
    exp_t sb[$];
    logic [15:0] ref_mem [256];
    logic [15:0] mem [256];
    logic [15:0] pipe [RL];
    logic        mem_ready = 1'b0;
    exp_t        e;
    logic [1:0]  st;

    dram_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_wren(core_wren),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_end(core_end),
        .dram_q(dram_q), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_wren(dram_wren), .core_rdata(core_rdata), .core_status(core_status),
        .grant_id(grant_id), .all_done(all_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] a);
        if (a == 8'h10) return 16'hBEEF;
        return {a ^ 8'h5A, ~a};
    endfunction

    // DRAM model: registered read pipeline of RL stages, write on dram_wren.
    always @(posedge clk) begin
        if (rst && !mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
            mem_ready <= 1'b1;
        end else if (dram_wren) begin
            mem[dram_addr[7:0]] <= dram_wdata;
        end
        pipe[0] <= mem[dram_addr[7:0]];
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign dram_q = pipe[RL-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every done status must match the oldest expected transaction; other cores track core_req.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                st = core_status[2*i +: 2];
                if (st == 2'b10) begin
                    done_count++;
                    if (sb.size() == 0) begin
                        check("sb_unexpected_done", 64'(i), 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        check("sb_core", 64'(i), 64'(e.core));
                        check("sb_grant", 64'(grant_id), 64'(e.core));
                        if (!e.wr) check("sb_rdata", 64'(core_rdata[i*DW +: DW]), 64'(e.data));
                    end
                end else begin
                    check("status_req", 64'(st), {63'd0, core_req[i]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_rd(input int c, input logic [15:0] a);
        core_wren[c]          = 1'b0;
        core_addr[c*AW +: AW] = a;
        core_req[c]           = 1'b1;
        sb.push_back('{c, 1'b0, a, ref_mem[a[7:0]]});
    endtask

    task automatic req_wr(input int c, input logic [15:0] a, input logic [15:0] d);
        core_wren[c]           = 1'b1;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = d;
        core_req[c]            = 1'b1;
        ref_mem[a[7:0]]        = d;
        sb.push_back('{c, 1'b1, a, d});
    endtask

    // Release each finished core unless kept requesting; release all once n dones are seen.
    task automatic wait_dones(input int n, input logic [NC-1:0] keep, input int budget);
        int target;
        int cyc;
        target = done_count + n;
        cyc    = 0;
        while (done_count < target && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (done_count >= target) begin
                core_req = '0;
            end else begin
                for (int i = 0; i < NC; i++)
                    if (core_status[2*i +: 2] == 2'b10 && !keep[i]) core_req[i] = 1'b0;
            end
        end
        check("wait_dones_in_budget", 64'(done_count >= target), 64'd1);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        core_req = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; core_req = '0; core_wren = '0; core_addr = '0; core_wdata = '0; core_end = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = pat(8'(a));

        // Reset values
        tick(); tick();
        check("rst_dram_addr", 64'(dram_addr), 64'd0);
        check("rst_dram_wdata", 64'(dram_wdata), 64'd0);
        check("rst_dram_wren", 64'(dram_wren), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_rdata", core_rdata, 64'd0);
        check("rst_all_done", 64'(all_done), 64'd0);
        core_req = 4'b0101;
        #1;
        check("rst_status_follows_req", 64'(core_status), 64'h11);
        core_req = '0;
        rst = 1'b0;

        // Single read, core 1, addr 0x0010
        tick();
        req_rd(1, 16'h0010);
        tick();
        check("rd_addr_n1", 64'(dram_addr), 64'h0010);
        check("rd_wren_n1", 64'(dram_wren), 64'd0);
        check("rd_status_wait", 64'(core_status[3:2]), 64'd1);
        tick(); tick(); tick();
        check("rd_status_done_n4", 64'(core_status[3:2]), 64'd2);
        check("rd_rdata1", 64'(core_rdata[31:16]), 64'hBEEF);
        check("rd_other_slices", core_rdata & 64'hFFFF_FFFF_0000_FFFF, 64'd0);
        core_req[1] = 1'b0;

        // Single write, core 2, 0x1234 -> 0x0003
        tick();
        req_wr(2, 16'h0003, 16'h1234);
        tick();
        check("wr_wren_n1", 64'(dram_wren), 64'd1);
        check("wr_addr_n1", 64'(dram_addr), 64'h0003);
        check("wr_data_n1", 64'(dram_wdata), 64'h1234);
        tick();
        check("wr_wren_n2", 64'(dram_wren), 64'd0);
        check("wr_status_done_n2", 64'(core_status[5:4]), 64'd2);
        check("wr_rdata_unchanged", core_rdata, 64'h0000_0000_BEEF_0000);
        core_req[2] = 1'b0;
        tick();
        check("wr_wren_n3", 64'(dram_wren), 64'd0);

        // Round robin from rr_ptr 0 with continuous re-requests: 0,1,2,3,0
        apply_reset();
        for (int c = 0; c < NC; c++) req_rd(c, 16'(16'h0020 + c));
        sb.push_back('{0, 1'b0, 16'h0020, ref_mem[8'h20]});
        wait_dones(5, 4'hF, 40);

        // Request dropped during WAIT still completes
        tick();
        req_rd(0, 16'h0040);
        tick(); tick();
        core_req[0] = 1'b0;
        tick();
        check("drop_status_idle", 64'(core_status[1:0]), 64'd0);
        tick();
        check("drop_status_done_n4", 64'(core_status[1:0]), 64'd2);
        check("drop_rdata0", 64'(core_rdata[15:0]), 64'(ref_mem[8'h40]));

        // Reset during WAIT of a core 3 read
        tick();
        req_rd(3, 16'h0050);
        tick(); tick();
        rst = 1'b1;
        core_req = '0;
        sb.delete();
        tick();
        check("midrst_wren", 64'(dram_wren), 64'd0);
        check("midrst_grant", 64'(grant_id), 64'd0);
        check("midrst_addr", 64'(dram_addr), 64'd0);
        check("midrst_rdata", core_rdata, 64'd0);
        check("midrst_status", 64'(core_status), 64'd0);
        rst = 1'b0;
        tick(); tick(); tick();

        // rr_ptr cleared by reset: cores 0 and 3 contend, 0 first; core 3 reads back the write
        req_rd(0, 16'h0011);
        req_rd(3, 16'h0003);
        wait_dones(2, 4'h0, 30);
        tick();

        // End aggregation: pulses at cycles 5, 9, 12, 20
        apply_reset();
        for (int t = 0; t < 26; t++) begin
            check("all_done_cycle", 64'(all_done), 64'(t >= 21));
            core_end = '0;
            if (t == 5)  core_end[0] = 1'b1;
            if (t == 9)  core_end[1] = 1'b1;
            if (t == 12) core_end[2] = 1'b1;
            if (t == 20) core_end[3] = 1'b1;
            tick();
        end
        core_end = '0;
        rst = 1'b1;
        tick();
        check("all_done_cleared", 64'(all_done), 64'd0);
        rst = 1'b0;
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shared data-memory arbiter on the DRAM side of the multi-core array. Each core raises a request with an address, write data and write enable. The arbiter grants one core at a time in round-robin order and drives the single-port DRAM. It returns read data and a 2-bit status per core, and also aggregates the cores' end-of-process flags into one completion signal.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (≥2)
- ADDR_W, 16, DRAM address width
- DATA_W, 16, DRAM data width
- RD_LAT, 2, DRAM read latency in cycles from address presented to dram_q valid (≥1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  NUM_CORES  per-core access request, held until DONE status seen
- core_wren  in  NUM_CORES  per-core write (1) / read (0) qualifier
- core_addr  in  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data
- core_end  in  NUM_CORES  per-core end_process flag
- dram_q  in  DATA_W  DRAM read data
- dram_addr  out  ADDR_W  registered DRAM address
- dram_wdata  out  DATA_W  registered DRAM write data
- dram_wren  out  1  registered DRAM write strobe, one-cycle pulse
- core_rdata  out  NUM_CORES*DATA_W  packed per-core read data, registered
- core_status  out  2*NUM_CORES  per-core status; 00 idle, 01 waiting, 10 done
- grant_id  out  log2(NUM_CORES)  index of core currently served
- all_done  out  1  all cores have signalled end

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, any core_req high:
  - winner = first requesting core at or after rr_ptr, wrapping modulo NUM_CORES.
  - Register grant_id, dram_addr, dram_wdata and dram_wren from the winner, then go to ACCESS.
- IDLE, no request: stay in IDLE; dram_wren = 0.
- ACCESS: DRAM sees the address this cycle. Clear dram_wren at the end of the cycle. A write goes to DONE; a read goes to WAIT with the counter cleared.
- WAIT: lasts exactly RD_LAT cycles. In the last cycle, capture dram_q into the core_rdata slice of grant_id, then go to DONE.
- DONE: lasts one cycle. Set rr_ptr = grant_id+1 (wraps to 0), then go to IDLE.
- core_status[i] is combinational:
  - 10 if state==DONE and grant_id==i;
  - else 01 if core_req[i];
  - else 00.
- core_rdata slices hold their value until the next read completion for the same core. Writes never change core_rdata.
- A core dropping core_req mid-transaction does not abort it. The access completes and DONE still occurs.
- core_req still high in the cycle after DONE is taken as a new request.
- all_done: per-core sticky flags are set when core_end[i] is high and cleared only by rst. all_done = registered AND of the flags.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, dram_addr 0, dram_wdata 0, dram_wren 0, all core_rdata 0, sticky flags 0, all_done 0. core_status then follows core_req (01/00).
- rst mid-transaction: abandon the access at once and return to IDLE next cycle. Do not update core_rdata and do not pulse DONE.

## Timing
- Request first sampled in IDLE at cycle N:
  - dram_addr/dram_wren valid in cycle N+1.
  - Write: done status in cycle N+2.
  - Read: dram_q captured at the end of cycle N+1+RD_LAT; done status and valid core_rdata in cycle N+2+RD_LAT.
- Service time per access: write 3 cycles (IDLE, ACCESS, DONE); read 3+RD_LAT cycles.
- No pipelining; only one outstanding DRAM access.
- dram_wren is high for exactly one cycle per write and never during a read.
- all_done rises one cycle after the last core_end is first seen high.

## Test plan
- Single read, RD_LAT=2: core 1 requests read of addr 0x0010 and DRAM returns 0xBEEF -> dram_addr=0x0010 at N+1, core_status[1]=10 and core_rdata[1]=0xBEEF at N+4, other slices unchanged.
- Single write: core 2 writes 0x1234 to 0x0003 -> dram_wren high only at N+1 with addr 0x0003 and data 0x1234; core_status[2]=10 at N+2; core_rdata unchanged.
- Round robin: all 4 cores request reads and keep re-requesting -> grant order 0,1,2,3,0; non-served requesters show 01 throughout.
- Request drop: core 0 deasserts core_req during WAIT -> access still completes, core_rdata[0] updated, DONE status pulses at N+4.
- Reset mid-read: assert rst during WAIT -> next cycle state IDLE, dram_wren 0, rr_ptr 0, core_rdata all 0, no done status.
- End aggregation: core_end pulsed one cycle each at cycles 5, 9, 12, 20 -> all_done 0 until cycle 21, then high until rst.
